// File: rtl/dsky_keyboard.sv
// dsky_keyboard
//   DSKY keypad responder on the CPU input-channel side. Raw key lines are
//   synchronized and debounced. Presses with more than one key down are
//   rejected. Each accepted keystroke is encoded to its 5-bit AGC keycode and
//   queued in a small FIFO. The FIFO head is presented as input channel 15,
//   together with a keyrupt request level.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed to
//                    accept a press or a release (>= 2)
//   CNT_W            debounce counter width (must hold DEBOUNCE_CYCLES)
//   FIFO_AW          FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk          system clock, posedge
//   reset        synchronous, active-high reset
//   key_raw      [17:0] raw key lines, active-high, asynchronous to clk
//                [9:0] digits 0-9, [10] VERB, [11] NOUN, [12] PLUS,
//                [13] MINUS, [14] ENTR, [15] CLR, [16] KEY REL, [17] RSET
//   rd_strobe    one-cycle CPU read of channel 15, pops the FIFO head
//   chan15_data  [15:0] {11'b0, head keycode}, zero when the FIFO is empty
//   keyrupt_req  high while the FIFO holds at least one keycode
//   overflow     sticky; set when an accepted key is dropped on a full FIFO
module dsky_keyboard #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int FIFO_AW         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] key_raw,
  input  logic        rd_strobe,
  output logic [15:0] chan15_data,
  output logic        keyrupt_req,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS    = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;
  localparam logic [1:0] ST_REL      = 2'd3;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [FIFO_AW:0]   FIFO_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   FIFO_EMPTY = '0;

  // True when exactly one key line is active.
  function automatic logic is_one_hot(input logic [17:0] v);
    is_one_hot = (v != 18'd0) && ((v & (v - 18'd1)) == 18'd0);
  endfunction

  // Maps a one-hot key vector to its AGC keycode (octal values).
  function automatic logic [4:0] encode(input logic [17:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (v[i]) idx = 5'(i);
    end
    case (idx)
      5'd0:    encode = 5'o20;
      5'd1:    encode = 5'o01;
      5'd2:    encode = 5'o02;
      5'd3:    encode = 5'o03;
      5'd4:    encode = 5'o04;
      5'd5:    encode = 5'o05;
      5'd6:    encode = 5'o06;
      5'd7:    encode = 5'o07;
      5'd8:    encode = 5'o10;
      5'd9:    encode = 5'o11;
      5'd10:   encode = 5'o21;
      5'd11:   encode = 5'o37;
      5'd12:   encode = 5'o32;
      5'd13:   encode = 5'o33;
      5'd14:   encode = 5'o34;
      5'd15:   encode = 5'o36;
      5'd16:   encode = 5'o31;
      5'd17:   encode = 5'o22;
      default: encode = 5'o00;
    endcase
  endfunction

  // ---- stage p0/p1: two-flop synchronizer, sync_p1 feeds the debouncer ----
  logic [17:0] sync_p0;
  logic [17:0] sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce FSM on sync_p1 ----
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [17:0]      cap;
  logic             push;
  logic [4:0]       push_code;

  // The captured vector must stay stable until the count completes. The key
  // is only queued when the vector is one-hot, but the FSM always goes on to
  // wait for a full release, so a held or chorded key never repeats.
  assign push      = (state == ST_PRESS) && (sync_p1 == cap) &&
                     (cnt == CNT_LAST) && is_one_hot(cap);
  assign push_code = encode(cap);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_p1 != 18'd0) begin
            cap   <= sync_p1;
            cnt   <= CNT_ONE;
            state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (sync_p1 != cap) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= ST_WAIT_REL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_WAIT_REL: begin
          if (sync_p1 == 18'd0) begin
            cnt   <= CNT_ONE;
            state <= ST_REL;
          end
        end
        ST_REL: begin
          if (sync_p1 != 18'd0) begin
            state <= ST_WAIT_REL;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- keycode FIFO with registered channel-15 outputs ----
  logic [4:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic               pop_ok;
  logic               push_ok;
  logic               drop;
  logic [FIFO_AW-1:0] rd_ptr_n;
  logic [FIFO_AW-1:0] wr_ptr_n;
  logic [FIFO_AW:0]   count_after_pop;
  logic [FIFO_AW:0]   count_n;
  logic [4:0]         head_n;

  // A pop on an empty FIFO is ignored. A push into a full FIFO only succeeds
  // when a pop frees the head slot on the same edge.
  assign pop_ok  = rd_strobe && (count != FIFO_EMPTY);
  assign push_ok = push && ((count != FIFO_FULL) || pop_ok);
  assign drop    = push && !push_ok;

  always_comb begin
    rd_ptr_n        = rd_ptr + FIFO_AW'(pop_ok);
    wr_ptr_n        = wr_ptr + FIFO_AW'(push_ok);
    count_after_pop = count - (FIFO_AW + 1)'(pop_ok);
    count_n         = count_after_pop + (FIFO_AW + 1)'(push_ok);
    // Predict the head after this edge so the outputs come straight from
    // flops: if nothing survives the pop, the head is the entry being pushed
    // (or nothing); otherwise it is an entry already stored in mem.
    if (count_after_pop == FIFO_EMPTY) begin
      head_n = push_ok ? push_code : 5'd0;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      chan15_data <= 16'h0000;
      keyrupt_req <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      chan15_data <= {11'b0, head_n};
      keyrupt_req <= (count_n != FIFO_EMPTY);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dsky_keyboard.sv
// tb_dsky_keyboard
//   Directed bench for dsky_keyboard with DEBOUNCE_CYCLES = 4. A held key
//   is queued on the 6th rising edge after it is applied.
module tb_dsky_keyboard;

  logic        clk;
  logic        reset;
  logic [17:0] key_raw;
  logic        rd_strobe;
  logic [15:0] chan15_data;
  logic        keyrupt_req;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  dsky_keyboard #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .rd_strobe(rd_strobe),
    .chan15_data(chan15_data),
    .keyrupt_req(keyrupt_req),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop;
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  // Single keystroke: hold long enough to be queued, then fully release.
  task automatic press_release(input int idx);
    key_raw = 18'd1 << idx;
    repeat (8) tick();
    key_raw = '0;
    repeat (8) tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    key_raw   = '0;
    rd_strobe = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();
    checks++;
    if (chan15_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %o expected %o", chan15_data, 16'h0000);
    end
    checks++;
    if (keyrupt_req !== 1'b0) begin
      errors++; $display("FAIL reset_keyrupt: got %b expected 0", keyrupt_req);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    key_raw = 18'd1 << 11;
    repeat (5) tick();
    checks++;
    if (keyrupt_req !== 1'b0) begin
      errors++; $display("FAIL noun_early: got keyrupt %b expected 0 after 5 edges", keyrupt_req);
    end
    tick();
    checks++;
    if (keyrupt_req !== 1'b1) begin
      errors++; $display("FAIL noun_keyrupt: got %b expected 1 after 6 edges", keyrupt_req);
    end
    checks++;
    if (chan15_data !== 16'o000037) begin
      errors++; $display("FAIL noun_code: got %o expected %o", chan15_data, 16'o000037);
    end
    key_raw = '0;
    pop();
    checks++;
    if (chan15_data !== 16'h0000 || keyrupt_req !== 1'b0) begin
      errors++; $display("FAIL noun_pop: got data %o keyrupt %b expected 0 0", chan15_data, keyrupt_req);
    end
    repeat (10) tick();
  endtask

  task automatic test_glitch;
    key_raw = 18'd1 << 3;
    repeat (2) tick();
    key_raw = '0;
    repeat (10) tick();
    checks++;
    if (keyrupt_req !== 1'b0 || chan15_data !== 16'h0000) begin
      errors++; $display("FAIL glitch: got data %o keyrupt %b expected 0 0", chan15_data, keyrupt_req);
    end
    key_raw = 18'd1 << 0;
    repeat (6) tick();
    checks++;
    if (chan15_data !== 16'o000020 || keyrupt_req !== 1'b1) begin
      errors++; $display("FAIL digit0: got data %o keyrupt %b expected %o 1", chan15_data, keyrupt_req, 16'o000020);
    end
    key_raw = '0;
    repeat (10) tick();
    pop();
  endtask

  task automatic test_multikey;
    key_raw = (18'd1 << 10) | (18'd1 << 14);
    repeat (10) tick();
    key_raw = '0;
    repeat (10) tick();
    checks++;
    if (keyrupt_req !== 1'b0 || chan15_data !== 16'h0000) begin
      errors++; $display("FAIL chord: got data %o keyrupt %b expected 0 0", chan15_data, keyrupt_req);
    end
    press_release(5);
    checks++;
    if (chan15_data !== 16'o000005) begin
      errors++; $display("FAIL digit5: got %o expected %o", chan15_data, 16'o000005);
    end
    pop();
    checks++;
    if (keyrupt_req !== 1'b0 || chan15_data !== 16'h0000) begin
      errors++; $display("FAIL digit5_only: got data %o keyrupt %b expected 0 0", chan15_data, keyrupt_req);
    end
  endtask

  task automatic test_hold;
    key_raw = 18'd1 << 14;
    repeat (100) tick();
    checks++;
    if (chan15_data !== 16'o000034) begin
      errors++; $display("FAIL entr_hold: got %o expected %o", chan15_data, 16'o000034);
    end
    key_raw = '0;
    repeat (2) tick();
    key_raw = 18'd1 << 14;
    repeat (20) tick();
    key_raw = '0;
    repeat (10) tick();
    pop();
    checks++;
    if (keyrupt_req !== 1'b0 || chan15_data !== 16'h0000) begin
      errors++; $display("FAIL entr_repeat: got data %o keyrupt %b expected 0 0", chan15_data, keyrupt_req);
    end
    key_raw = 18'd1 << 14;
    repeat (6) tick();
    checks++;
    if (chan15_data !== 16'o000034 || keyrupt_req !== 1'b1) begin
      errors++; $display("FAIL entr_second: got data %o keyrupt %b expected %o 1", chan15_data, keyrupt_req, 16'o000034);
    end
    key_raw = '0;
    repeat (10) tick();
    pop();
  endtask

  task automatic test_overflow;
    logic [15:0] exp_q [5];
    exp_q[0] = 16'o01; exp_q[1] = 16'o02; exp_q[2] = 16'o03;
    exp_q[3] = 16'o04; exp_q[4] = 16'o00;
    for (int k = 1; k <= 4; k++) press_release(k);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_early: got %b expected 0 with 4 queued", overflow);
    end
    press_release(9);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (chan15_data !== exp_q[k]) begin
        errors++; $display("FAIL ovf_read%0d: got %o expected %o", k, chan15_data, exp_q[k]);
      end
      pop();
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_full_push_pop;
    logic [15:0] exp_q [5];
    exp_q[0] = 16'o02; exp_q[1] = 16'o03; exp_q[2] = 16'o04;
    exp_q[3] = 16'o11; exp_q[4] = 16'o00;
    do_reset();
    for (int k = 1; k <= 4; k++) press_release(k);
    key_raw = 18'd1 << 9;
    repeat (5) tick();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    key_raw = '0;
    repeat (8) tick();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_ovf: got %b expected 0", overflow);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (chan15_data !== exp_q[k]) begin
        errors++; $display("FAIL full_pushpop_read%0d: got %o expected %o", k, chan15_data, exp_q[k]);
      end
      pop();
    end
  endtask

  task automatic test_back_to_back;
    // Pop on an empty FIFO coinciding with a push: the push must land.
    key_raw = 18'd1 << 2;
    repeat (5) tick();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    checks++;
    if (chan15_data !== 16'o000002 || keyrupt_req !== 1'b1) begin
      errors++; $display("FAIL empty_pushpop: got data %o keyrupt %b expected %o 1", chan15_data, keyrupt_req, 16'o000002);
    end
    key_raw = '0;
    repeat (10) tick();
    pop();
    checks++;
    if (keyrupt_req !== 1'b0) begin
      errors++; $display("FAIL empty_pushpop_drain: got keyrupt %b expected 0", keyrupt_req);
    end
  endtask

  task automatic test_reset_mid_press;
    key_raw = 18'd1 << 7;
    repeat (4) tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (chan15_data !== 16'h0000 || keyrupt_req !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got data %o keyrupt %b ovf %b expected 0 0 0", chan15_data, keyrupt_req, overflow);
    end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (keyrupt_req !== 1'b0) begin
      errors++; $display("FAIL midreset_early: got keyrupt %b expected 0 after 5 edges", keyrupt_req);
    end
    tick();
    checks++;
    if (chan15_data !== 16'o000007 || keyrupt_req !== 1'b1) begin
      errors++; $display("FAIL midreset_code: got data %o keyrupt %b expected %o 1", chan15_data, keyrupt_req, 16'o000007);
    end
    key_raw = '0;
    repeat (10) tick();
  endtask

  initial begin
    reset     = 1'b1;
    key_raw   = '0;
    rd_strobe = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_multikey();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
